// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-to-host byte receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    // Odd parity over data plus parity bit: an odd number of ones is a good frame.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, glitch filter and registered falling-edge pulse for one raw PS/2 line.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   filt_r;
    logic                   prev_r;
    logic                   synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain; idle-high line so it resets to ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], line_in};
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive samples of the new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= '0;
            filt_r <= 1'b1;
        end else if (synced_s == filt_r) begin
            cnt_r  <= '0;
        end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
            filt_r <= synced_s;
            cnt_r  <= '0;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
        end
    end

    // Previous filtered level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= filt_r;
        end
    end

    assign fall = prev_r & ~filt_r;

endmodule

// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host receiver: recovers 11-bit frames and emits one byte per good frame.
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0]   data_sync_r;
    logic                     data_s;
    logic                     fall_s;
    rx_state_t                state_r;
    logic [2:0]               bit_cnt_r;
    logic [PS2_DATA_BITS-1:0] shift_r;
    logic                     parity_r;
    logic [TW-1:0]            to_cnt_r;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2_clk),
        .fall    (fall_s)
    );

    // Data line needs only synchronizing; it is sampled on clock falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sync_r <= '1;
        end else begin
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign data_s = data_sync_r[SYNC_STAGES-1];

    // Frame FSM with timeout; the timeout check precedes fall so a simultaneous fall is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            to_cnt_r   <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (state_r != IDLE && to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                state_r   <= IDLE;
                bit_cnt_r <= 3'd0;
                to_cnt_r  <= '0;
                frame_err <= 1'b1;
            end else if (state_r == IDLE) begin
                to_cnt_r <= '0;
                if (fall_s && !data_s) begin
                    state_r   <= DATA;
                    bit_cnt_r <= 3'd0;
                end else begin
                    state_r   <= IDLE;
                end
            end else if (fall_s) begin
                to_cnt_r <= '0;
                case (state_r)
                    DATA: begin
                        shift_r[bit_cnt_r] <= data_s;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= PARITY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                    PARITY: begin
                        parity_r <= data_s;
                        state_r  <= STOP;
                    end
                    STOP: begin
                        state_r   <= IDLE;
                        bit_cnt_r <= 3'd0;
                        if (!data_s) begin
                            frame_err <= 1'b1;
                        end else if (!odd_parity_ok(shift_r, parity_r)) begin
                            parity_err <= 1'b1;
                        end else begin
                            byte_out   <= shift_r;
                            byte_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end
        end
    end

endmodule
